// File: rtl/mesh_pkg.sv
// Shared definitions for the mesh NoC receive endpoint: flit field layout,
// Wishbone window base and register offsets.
package mesh_pkg;

    // Flit layout: [33]=valid [32:31]=row [30:29]=col [28:0]=body
    localparam int FLIT_W     = 34;
    localparam int FLIT_VALID = 33;
    localparam int FLIT_ROW_H = 32;
    localparam int FLIT_ROW_L = 31;
    localparam int FLIT_COL_H = 30;
    localparam int FLIT_COL_L = 29;
    localparam int BODY_W     = 29;
    localparam int BODY_H     = 28;

    // Wishbone window selected by adr[31:28]
    localparam logic [3:0] RX_BASE = 4'h9;

    // Register index taken from adr[3:2]
    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_DROPS  = 2'd2,
        REG_RSVD   = 2'd3
    } rx_reg_e;

endpackage

// File: rtl/mesh_rx_fifo.sv
// Synchronous FIFO holding received flit bodies. A push while full is only
// accepted when a pop happens in the same cycle. Storage is not reset; only
// pointers and occupancy are.
module mesh_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 29
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [WIDTH-1:0]       o_head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_wr_en;
    logic             w_rd_en;

    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    assign w_rd_en = i_pop & ~o_empty;
    assign w_wr_en = i_push & (~o_full | w_rd_en);

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage, written at the current write pointer
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/mesh_eject_rx.sv
// Mesh NoC receive endpoint: filters flits from the router eject port by
// target id, queues accepted bodies and exposes them to the local CPU through
// a four-register Wishbone window at 0x9xxxxxxx.
// Optional feature macro: MESH_RX_IRQ_EN adds the rx_irq level interrupt.
module mesh_eject_rx
    import mesh_pkg::*;
#(
    parameter logic [3:0] MY_ID = 4'b0000,
    parameter int         DEPTH = 4,
    parameter int         CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] eject_flit,
    input  logic [31:0]       local_wb_adr,
    input  logic [31:0]       local_wb_dat_o,
    input  logic              local_wb_we,
    input  logic              local_wb_stb,
    output logic [31:0]       local_wb_dat_i,
`ifdef MESH_RX_IRQ_EN
    output logic              local_wb_ack,
    output logic              rx_irq
`else
    output logic              local_wb_ack
`endif
);

    localparam int CNT_FW = $clog2(DEPTH) + 1;

    logic [31:0]       r_dat;
    logic              r_ack;
    logic [CNT_W-1:0]  r_misroute;
    logic [CNT_W-1:0]  r_overflow;

    logic              w_flit_vld;
    logic              w_tgt_hit;
    logic              w_sel;
    logic              w_start;
    rx_reg_e           w_reg;
    logic              w_pop;
    logic              w_push;
    logic              w_misroute_ev;
    logic              w_overflow_ev;
    logic              w_clr;
    logic              w_full;
    logic              w_empty;
    logic [CNT_FW-1:0] w_count;
    logic [BODY_W-1:0] w_head;
    logic [31:0]       w_rd_val;
    logic              w_irq_bit;
    logic              w_unused;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Flit filtering: valid flits for this node are queued, others count as drops
    assign w_flit_vld    = eject_flit[FLIT_VALID];
    assign w_tgt_hit     = ({eject_flit[FLIT_ROW_H:FLIT_ROW_L],
                             eject_flit[FLIT_COL_H:FLIT_COL_L]} == MY_ID);
    assign w_misroute_ev = w_flit_vld & ~w_tgt_hit;

    // Bus decode: a transaction starts on a selected strobe not already being acked
    assign w_sel   = (local_wb_adr[31:28] == RX_BASE);
    assign w_start = local_wb_stb & w_sel & ~r_ack;
    assign w_reg   = rx_reg_e'(local_wb_adr[3:2]);
    assign w_pop   = w_start & ~local_wb_we & (w_reg == REG_DATA) & ~w_empty;
    assign w_clr   = w_start & local_wb_we & (w_reg == REG_DROPS);

    // A full FIFO still accepts a flit when the CPU pops in the same cycle
    assign w_push        = w_flit_vld & w_tgt_hit & (~w_full | w_pop);
    assign w_overflow_ev = w_flit_vld & w_tgt_hit & w_full & ~w_pop;

    // Write data is never stored and only part of the address is decoded
    assign w_unused = ^{local_wb_dat_o, local_wb_adr[27:4], local_wb_adr[1:0]};

    mesh_rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BODY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (eject_flit[BODY_H:0]),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_head  (w_head)
    );

`ifdef MESH_RX_IRQ_EN
    logic r_irq;
    logic w_irq_next;

    // Interrupt follows next-cycle occupancy: set by any push, cleared by the emptying pop
    assign w_irq_next = w_push | ~(w_empty | (w_pop & (w_count == CNT_FW'(1))));

    // Registered level interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_irq <= 1'b0;
        else        r_irq <= w_irq_next;
    end

    assign rx_irq    = r_irq;
    assign w_irq_bit = r_irq;
`else
    assign w_irq_bit = 1'b0;
`endif

    // Read value mux; DATA on an empty FIFO reads zero (no bypass of a same-cycle push)
    always_comb begin
        w_rd_val = 32'h0;
        if (!local_wb_we) begin
            case (w_reg)
                REG_DATA:   w_rd_val = w_empty ? 32'h0 : {1'b1, 2'b00, w_head};
                REG_STATUS: w_rd_val = {w_full, w_empty, 14'h0, 8'(w_count), 7'h0, w_irq_bit};
                REG_DROPS:  w_rd_val = {16'h0, 8'(r_misroute), 8'(r_overflow)};
                default:    w_rd_val = 32'h0;
            endcase
        end
    end

    // Single-cycle ack and registered read data for each started transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack <= 1'b0;
            r_dat <= 32'h0;
        end else begin
            r_ack <= w_start;
            if (w_start) r_dat <= w_rd_val;
        end
    end

    // Saturating drop counters; a drop in the clear cycle survives the clear as 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misroute <= '0;
            r_overflow <= '0;
        end else if (w_clr) begin
            r_misroute <= w_misroute_ev ? CNT_W'(1) : '0;
            r_overflow <= w_overflow_ev ? CNT_W'(1) : '0;
        end else begin
            if (w_misroute_ev) r_misroute <= sat_inc(r_misroute);
            if (w_overflow_ev) r_overflow <= sat_inc(r_overflow);
        end
    end

    assign local_wb_ack   = r_ack;
    assign local_wb_dat_i = r_dat;

endmodule

// File: tb/tb_mesh_eject_rx.sv
// Directed bench for mesh_eject_rx (MY_ID=4'b0110, DEPTH=4) with a read-data scoreboard.
module tb_mesh_eject_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [33:0] eject_flit;
    logic [31:0] local_wb_adr;
    logic [31:0] local_wb_dat_o;
    logic        local_wb_we;
    logic        local_wb_stb;
    logic [31:0] local_wb_dat_i;
    logic        local_wb_ack;
`ifdef MESH_RX_IRQ_EN
    logic        rx_irq;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] sb[$];

    localparam logic [31:0] A_DATA   = 32'h9000_0000;
    localparam logic [31:0] A_STATUS = 32'h9000_0004;
    localparam logic [31:0] A_DROPS  = 32'h9000_0008;
    localparam logic [3:0]  ME       = 4'b0110;
    localparam logic [3:0]  OTHER    = 4'b0011;

    mesh_eject_rx #(.MY_ID(4'b0110), .DEPTH(4), .CNT_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .eject_flit     (eject_flit),
        .local_wb_adr   (local_wb_adr),
        .local_wb_dat_o (local_wb_dat_o),
        .local_wb_we    (local_wb_we),
        .local_wb_stb   (local_wb_stb),
        .local_wb_dat_i (local_wb_dat_i),
`ifdef MESH_RX_IRQ_EN
        .local_wb_ack   (local_wb_ack),
        .rx_irq         (rx_irq)
`else
        .local_wb_ack   (local_wb_ack)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [33:0] mk(input logic [3:0] tgt, input logic [28:0] body);
        return {1'b1, tgt, body};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One Wishbone transaction, optionally with a flit presented in the start cycle.
    // Strobe is held one extra cycle to confirm ack is a single pulse.
    task automatic wb(input string tag, input logic [31:0] a, input logic w,
                      input bit rd_chk, input logic [31:0] exp, input logic [33:0] f);
        logic [31:0] e;
        @(negedge clk);
        local_wb_adr   = a;
        local_wb_we    = w;
        local_wb_dat_o = 32'hDEAD_BEEF;
        local_wb_stb   = 1'b1;
        eject_flit     = f;
        if (rd_chk) sb.push_back(exp);
        @(posedge clk); #1;
        eject_flit = '0;
        check({tag, "_ack"}, {31'b0, local_wb_ack}, 32'd1);
        if (rd_chk) begin
            e = sb.pop_front();
            if (local_wb_ack) check(tag, local_wb_dat_i, e);
        end
        @(posedge clk); #1;
        check({tag, "_ackpulse"}, {31'b0, local_wb_ack}, 32'd0);
        local_wb_stb = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        wb(tag, a, 1'b0, 1'b1, exp, '0);
    endtask

    task automatic send(input logic [33:0] f);
        @(negedge clk);
        eject_flit = f;
        @(negedge clk);
        eject_flit = '0;
    endtask

    initial begin
        rst_n          = 1'b0;
        eject_flit     = '0;
        local_wb_adr   = '0;
        local_wb_dat_o = '0;
        local_wb_we    = 1'b0;
        local_wb_stb   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'b0, local_wb_ack}, 32'd0);
        check("rst_dat", local_wb_dat_i, 32'h0);
`ifdef MESH_RX_IRQ_EN
        check("rst_irq", {31'b0, rx_irq}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        rd("rst_status", A_STATUS, 32'h4000_0000);
        rd("rst_drops",  A_DROPS,  32'h0000_0000);

        // Unselected strobe: never acked
        @(negedge clk);
        local_wb_adr = 32'h8000_0000;
        local_wb_stb = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check("unsel_noack", {31'b0, local_wb_ack}, 32'd0);
        end
        local_wb_stb = 1'b0;

        // Test 1: single flit to this node
        send({1'b1, 2'b01, 2'b10, 28'b0, 1'b1});
`ifdef MESH_RX_IRQ_EN
        @(posedge clk); #1;
        check("irq_set", {31'b0, rx_irq}, 32'd1);
`endif
        rd("t1_status1", A_STATUS, 32'h0000_0100 | 32'(`ifdef MESH_RX_IRQ_EN 1 `else 0 `endif));
        wb("t1_wr_data", A_DATA, 1'b1, 1'b0, 32'h0, '0);
        rd("t1_status2", A_STATUS, 32'h0000_0100 | 32'(`ifdef MESH_RX_IRQ_EN 1 `else 0 `endif));
        rd("t1_data", A_DATA, 32'h8000_0001);
        rd("t1_status3", A_STATUS, 32'h4000_0000);

        // Test 2: misrouted flit
        send(mk(OTHER, 29'd5));
        rd("t2_drops", A_DROPS, 32'h0000_0100);
        rd("t2_status", A_STATUS, 32'h4000_0000);
        wb("t2_clr", A_DROPS, 1'b1, 1'b0, 32'h0, '0);
        rd("t2_drops_clr", A_DROPS, 32'h0000_0000);

        // Test 3: five back-to-back flits into a 4-deep FIFO
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            eject_flit = mk(ME, 29'(i));
        end
        @(negedge clk);
        eject_flit = '0;
        rd("t3_status", A_STATUS, 32'h8000_0400 | 32'(`ifdef MESH_RX_IRQ_EN 1 `else 0 `endif));
        rd("t3_drops", A_DROPS, 32'h0000_0001);
        for (int i = 1; i <= 4; i++) rd("t3_data", A_DATA, 32'h8000_0000 | 32'(i));
        rd("t3_data_empty", A_DATA, 32'h0);
        wb("t3_clr", A_DROPS, 1'b1, 1'b0, 32'h0, '0);

        // Test 4: full FIFO, push and pop in the same cycle
        for (int i = 10; i <= 13; i++) send(mk(ME, 29'(i)));
        wb("t4_data", A_DATA, 1'b0, 1'b1, 32'h8000_000A, mk(ME, 29'd14));
        rd("t4_status", A_STATUS, 32'h8000_0400 | 32'(`ifdef MESH_RX_IRQ_EN 1 `else 0 `endif));
        rd("t4_drops", A_DROPS, 32'h0000_0000);
        for (int i = 11; i <= 14; i++) rd("t4_drain", A_DATA, 32'h8000_0000 | 32'(i));

        // Empty FIFO: push and read same cycle reads 0 but stores the flit
        wb("byp_data", A_DATA, 1'b0, 1'b1, 32'h0, mk(ME, 29'h55));
        rd("byp_status", A_STATUS, 32'h0000_0100 | 32'(`ifdef MESH_RX_IRQ_EN 1 `else 0 `endif));
        rd("byp_data2", A_DATA, 32'h8000_0055);
`ifdef MESH_RX_IRQ_EN
        check("irq_clr", {31'b0, rx_irq}, 32'd0);
`endif

        // Test 5: misroute counter saturation and clear collision
        @(negedge clk);
        eject_flit = mk(OTHER, 29'd7);
        repeat (300) @(negedge clk);
        eject_flit = '0;
        rd("t5_sat", A_DROPS, 32'h0000_FF00);
        wb("t5_clr", A_DROPS, 1'b1, 1'b0, 32'h0, mk(OTHER, 29'd8));
        rd("t5_after_clr", A_DROPS, 32'h0000_0100);

        // Test 6: reset during a strobe with entries queued
        send(mk(ME, 29'd21));
        send(mk(ME, 29'd22));
        rd("t6_status", A_STATUS, 32'h0000_0200 | 32'(`ifdef MESH_RX_IRQ_EN 1 `else 0 `endif));
        @(negedge clk);
        local_wb_adr = A_STATUS;
        local_wb_we  = 1'b0;
        local_wb_stb = 1'b1;
        rst_n        = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            check("t6_noack", {31'b0, local_wb_ack}, 32'd0);
        end
`ifdef MESH_RX_IRQ_EN
        check("t6_irq_rst", {31'b0, rx_irq}, 32'd0);
`endif
        local_wb_stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd("t6_status_after", A_STATUS, 32'h4000_0000);
        rd("t6_drops_after", A_DROPS, 32'h0000_0000);
`ifdef MESH_RX_IRQ_EN
        send(mk(ME, 29'd23));
        check("t6_irq_push", {31'b0, rx_irq}, 32'd1);
`endif

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
